// File: rtl/seq_storage_set.sv
// rtl/seq_storage_set.sv - one transparent-high D latch and two independent rising-edge D flops sharing d/clk/rst
module seq_storage_set #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q_latch,
    output logic [WIDTH-1:0] q_dff0,
    output logic [WIDTH-1:0] q_dff1
);

    // Each storage element gets its own next-state net so no element feeds another.
    logic [WIDTH-1:0] latch_d;
    logic [WIDTH-1:0] latch_q;
    logic [WIDTH-1:0] dff0_d;
    logic [WIDTH-1:0] dff0_q;
    logic [WIDTH-1:0] dff1_d;
    logic [WIDTH-1:0] dff1_q;

    // Latch data path: reset wins over d while the latch is transparent.
    always_comb begin
        latch_d = d;
        if (rst) begin
            latch_d = '0;
        end
    end

    // Latch is transparent while clk is high and holds the falling-edge value while clk is low.
    always_latch begin
        if (clk) begin
            latch_q <= latch_d;
        end
    end

    // Flop data paths: plain capture of d; reset is applied in the sequential block.
    always_comb begin
        dff0_d = d;
        dff1_d = d;
    end

    // Primary flop: synchronous clear, otherwise capture d on the rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            dff0_q <= '0;
        end else begin
            dff0_q <= dff0_d;
        end
    end

    // Second flop: a separate instance with identical behaviour, not derived from the first.
    always_ff @(posedge clk) begin
        if (rst) begin
            dff1_q <= '0;
        end else begin
            dff1_q <= dff1_d;
        end
    end

    assign q_latch = latch_q;
    assign q_dff0  = dff0_q;
    assign q_dff1  = dff1_q;

endmodule

// File: tb/tb_seq_storage_set.sv
// tb/tb_seq_storage_set.sv - directed and randomized checks of latch and flop outputs with a flop scoreboard
`timescale 1ns/1ps
module tb_seq_storage_set;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] d;
    logic [W-1:0] q_latch;
    logic [W-1:0] q_dff0;
    logic [W-1:0] q_dff1;

    int errors;
    int checks;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] latch_model;

    seq_storage_set #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .d       (d),
        .q_latch (q_latch),
        .q_dff0  (q_dff0),
        .q_dff1  (q_dff1)
    );

    initial clk = 1'b0;
    always #100 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive inputs in the middle of the low phase and record what the flops must capture next.
    task automatic drive_low(input logic r, input logic [W-1:0] v);
        @(negedge clk);
        #50;
        rst = r;
        d   = v;
        exp_q.push_back(r ? '0 : v);
    endtask

    // Just after the rising edge, pop the expected flop value and compare both flops.
    task automatic edge_check(input string tag);
        logic [W-1:0] e;
        @(posedge clk);
        #1;
        checks++;
        assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL %s_sb: observed=empty expected=entry", tag);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_dff0"}, q_dff0, e);
            check({tag, "_dff1"}, q_dff1, e);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        d   = '0;

        // Reset held through a full period.
        @(posedge clk);
        #1;
        check("rst_latch_high", q_latch, 4'h0);
        @(negedge clk);
        #1;
        check("rst_latch", q_latch, 4'h0);
        check("rst_dff0", q_dff0, 4'h0);
        check("rst_dff1", q_dff1, 4'h0);

        // Release reset mid-low with d=1: nothing moves until the rising edge.
        #49;
        rst = 1'b0;
        d   = 4'h1;
        exp_q.push_back(4'h1);
        #40;
        check("rel_pre_dff0", q_dff0, 4'h0);
        check("rel_pre_dff1", q_dff1, 4'h0);
        check("rel_pre_latch", q_latch, 4'h0);
        edge_check("rel_edge");
        check("rel_latch_high", q_latch, 4'h1);

        // Toggle d within the high phase: latch tracks, flops hold.
        #20;
        d = 4'h0;
        #1;
        check("tog0_latch", q_latch, 4'h0);
        check("tog0_dff0", q_dff0, 4'h1);
        #20;
        d = 4'h1;
        #1;
        check("tog1_latch", q_latch, 4'h1);
        check("tog1_dff1", q_dff1, 4'h1);
        #20;
        d = 4'h0;
        #1;
        check("tog2_latch", q_latch, 4'h0);

        // Change d during low phase: latch holds its falling-edge value.
        drive_low(1'b0, 4'h5);
        #1;
        check("low_hold_latch", q_latch, 4'h0);
        #38;
        check("low_hold_dff0", q_dff0, 4'h1);
        edge_check("low_edge");
        check("low_edge_latch", q_latch, 4'h5);

        // Assert reset mid-low: flops and latch hold until the rising edge, then clear.
        drive_low(1'b1, 4'h5);
        #40;
        check("rsta_pre_latch", q_latch, 4'h5);
        check("rsta_pre_dff0", q_dff0, 4'h5);
        check("rsta_pre_dff1", q_dff1, 4'h5);
        edge_check("rsta_edge");
        check("rsta_edge_latch", q_latch, 4'h0);

        // Drop reset during high: latch follows d at once, flops wait for the next edge.
        #20;
        rst = 1'b0;
        #1;
        check("rstd_latch", q_latch, 4'h5);
        check("rstd_dff0", q_dff0, 4'h0);
        drive_low(1'b0, 4'h5);
        edge_check("rstd_edge");

        // Randomized d/rst, changed only mid-phase.
        for (int i = 0; i < 40; i++) begin
            logic         r;
            logic [W-1:0] v;
            logic [W-1:0] hv;
            logic [W-1:0] held;
            r = ($urandom_range(0, 4) == 0);
            v = W'($urandom);
            drive_low(r, v);
            edge_check("rnd");
            check("rnd_eq", q_dff0, q_dff1);
            latch_model = r ? '0 : v;
            check("rnd_latch", q_latch, latch_model);
            held = q_dff0;
            #49;
            hv = W'($urandom);
            d  = hv;
            #1;
            latch_model = r ? '0 : hv;
            check("rnd_latch_mid", q_latch, latch_model);
            check("rnd_hold_dff0", q_dff0, held);
            check("rnd_hold_dff1", q_dff1, held);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
